alu_exec_unit: RTL and testbench

- 8-bit execute-stage ALU that directly consumes the second-operand mux output (operand B) plus register operand A.
- Performs arithmetic and logic ops in one cycle; performs shifts iteratively, one bit per cycle.
- Registers result and flags, with a start/done handshake to the control FSM.
- Result feeds register-file writeback; flags feed the branch unit.

---
 rtl/alu_exec_unit.sv | 204 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops and iterative shifts.
// Ports: clk, reset (async, active-high), start/op/a/b in; busy, done, result
// and zero/carry/negative/overflow/illegal flags out, all registered.
module alu_exec_unit #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             illegal
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_PASSB = 4'd8;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         sop_q, sop_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               negative_q, negative_d;
    logic               overflow_q, overflow_d;
    logic               illegal_q, illegal_d;

    logic [SHAMT_W-1:0] k;
    logic               is_shift;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               alu_ill;
    logic [WIDTH-1:0]   sh_next;
    logic               sh_out;

    assign k        = b[SHAMT_W-1:0];
    assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    assign sum      = {1'b0, a} + {1'b0, b};
    // MSB of the widened difference is the unsigned borrow.
    assign diff     = {1'b0, a} - {1'b0, b};

    // Single-cycle datapath; a shift only reaches here with k == 0.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        unique case (1'b1)
            (op == OP_ADD): begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum[WIDTH-1] != a[WIDTH-1]);
            end
            (op == OP_SUB): begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (diff[WIDTH-1] != a[WIDTH-1]);
            end
            (op == OP_AND):   alu_res = a & b;
            (op == OP_OR):    alu_res = a | b;
            (op == OP_XOR):   alu_res = a ^ b;
            (op == OP_PASSB): alu_res = b;
            is_shift:         alu_res = a;
            default:          alu_ill = 1'b1;
        endcase
    end

    // One-bit shift step; sop_q holds op[1:0] of the captured shift.
    always_comb begin
        sh_next = shreg_q;
        sh_out  = 1'b0;
        case (sop_q)
            2'b01: begin
                sh_next = {shreg_q[WIDTH-2:0], 1'b0};
                sh_out  = shreg_q[WIDTH-1];
            end
            2'b10: begin
                sh_next = {1'b0, shreg_q[WIDTH-1:1]};
                sh_out  = shreg_q[0];
            end
            2'b11: begin
                sh_next = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
                sh_out  = shreg_q[0];
            end
            default: begin
                sh_next = shreg_q;
                sh_out  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        sop_d      = sop_q;
        done_d     = 1'b0;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        negative_d = negative_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_shift && (k != '0)) begin
                        shreg_d = a;
                        cnt_d   = k;
                        sop_d   = op[1:0];
                        state_d = SHIFT;
                    end else begin
                        done_d     = 1'b1;
                        result_d   = alu_res;
                        zero_d     = (alu_res == '0);
                        negative_d = alu_res[WIDTH-1];
                        carry_d    = alu_c;
                        overflow_d = alu_v;
                        illegal_d  = alu_ill;
                    end
                end
            end
            SHIFT: begin
                shreg_d = sh_next;
                cnt_d   = cnt_q - 1'b1;
                // Last step: the bit leaving now is the reported carry.
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    result_d   = sh_next;
                    zero_d     = (sh_next == '0);
                    negative_d = sh_next[WIDTH-1];
                    carry_d    = sh_out;
                    overflow_d = 1'b0;
                    illegal_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            sop_q      <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            sop_q      <= sop_d;
            done_q     <= done_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign negative = negative_q;
    assign overflow = overflow_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus
// randomized ops checked against an arithmetic reference model.
module tb_alu_exec_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] op = 4'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       busy, done, zero, carry, negative, overflow, illegal;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .zero(zero), .carry(carry), .negative(negative),
        .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference: flags packed as {zero, carry, negative, overflow, illegal}.
    task automatic model(input logic [3:0] o, input logic [7:0] x,
                         input logic [7:0] y, output logic [7:0] r,
                         output logic [4:0] f, output int lat);
        int sx, sy, s, k;
        logic c, v, il;
        logic signed [7:0] xs;
        sx = $signed(x);
        sy = $signed(y);
        k  = int'(y) % 8;
        c = 0; v = 0; il = 0; lat = 1; r = 8'h00;
        case (o)
            4'd0: begin
                r = x + y; c = (int'(x) + int'(y)) > 255;
                s = sx + sy; v = (s > 127) || (s < -128);
            end
            4'd1: begin
                r = x - y; c = x < y;
                s = sx - sy; v = (s > 127) || (s < -128);
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: begin
                r = x << k; if (k > 0) c = x[8-k];
            end
            4'd6: begin
                r = x >> k; if (k > 0) c = x[k-1];
            end
            4'd7: begin
                xs = x; r = xs >>> k; if (k > 0) c = x[k-1];
            end
            4'd8: r = y;
            default: begin r = 8'h00; il = 1; end
        endcase
        if (o >= 4'd5 && o <= 4'd7 && k > 0) lat = k + 1;
        f = {(r == 8'h00), c, r[7], v, il};
    endtask

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic run_op(input string nm, input logic [3:0] o,
                          input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] er, input logic [4:0] ef,
                          input int elat);
        int cyc, bcnt;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        cyc = 1; bcnt = 0;
        while (!done && cyc < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== elat || done !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: got %0d done=%b, want %0d", nm, cyc, done, elat);
        end
        checks++;
        if (bcnt !== elat - 1) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d, want %0d", nm, bcnt, elat - 1);
        end
        checks++;
        if (result !== er) begin
            errors++;
            $display("FAIL %s result: got %h, want %h", nm, result, er);
        end
        checks++;
        if ({zero, carry, negative, overflow, illegal} !== ef) begin
            errors++;
            $display("FAIL %s flags zcnvi: got %b, want %b", nm,
                     {zero, carry, negative, overflow, illegal}, ef);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== er) begin
            errors++;
            $display("FAIL %s hold: done=%b result=%h, want 0/%h", nm, done, result, er);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, result, zero, carry, negative, overflow, illegal} !== 15'd0) begin
            errors++;
            $display("FAIL reset outputs: got %h, want 0",
                     {busy, done, result, zero, carry, negative, overflow, illegal});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add;
        run_op("add_ovf", 4'd0, 8'h7F, 8'h01, 8'h80, 5'b00110, 1);
    endtask

    task automatic test_back_to_back;
        start = 1'b1; op = 4'd1; a = 8'h05; b = 8'h05;
        @(negedge clk);
        a = 8'h03; b = 8'h05;
        checks++;
        if (done !== 1'b1 || result !== 8'h00 || {zero, carry} !== 2'b10) begin
            errors++;
            $display("FAIL b2b first: done=%b res=%h zc=%b, want 1/00/10",
                     done, result, {zero, carry});
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 8'hFE ||
            {zero, carry, negative} !== 3'b011) begin
            errors++;
            $display("FAIL b2b second: done=%b res=%h zcn=%b, want 1/fe/011",
                     done, result, {zero, carry, negative});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b done drop: got %b, want 0", done);
        end
    endtask

    task automatic test_sra_ignore;
        logic [4:0] seen;
        start = 1'b1; op = 4'd7; a = 8'h90; b = 8'h03;
        @(negedge clk);
        start = 1'b0; seen[0] = busy;
        @(negedge clk);
        seen[1] = busy;
        start = 1'b1; op = 4'd0; a = 8'h01; b = 8'h01;
        @(negedge clk);
        start = 1'b0; seen[2] = busy; seen[3] = done;
        @(negedge clk);
        seen[4] = done;
        checks++;
        if (seen !== 5'b10111) begin
            errors++;
            $display("FAIL sra timing {done4,done3,busy3..1}: got %b, want 10111", seen);
        end
        checks++;
        if (result !== 8'hF2 || carry !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sra result: got %h c=%b busy=%b, want f2/0/0",
                     result, carry, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== 8'hF2) begin
            errors++;
            $display("FAIL sra ignored start: done=%b res=%h, want 0/f2", done, result);
        end
    endtask

    task automatic test_sll;
        run_op("sll1", 4'd5, 8'h81, 8'h01, 8'h02, 5'b01000, 2);
        run_op("sll0", 4'd5, 8'h81, 8'h08, 8'h81, 5'b00100, 1);
    endtask

    task automatic test_passb_illegal;
        run_op("passb", 4'd8, 8'h55, 8'h3C, 8'h3C, 5'b00000, 1);
        run_op("illegal", 4'hB, 8'h12, 8'h34, 8'h00, 5'b10001, 1);
        run_op("and_clr", 4'd2, 8'hF0, 8'h0F, 8'h00, 5'b10000, 1);
    endtask

    task automatic test_reset_midshift;
        int dones;
        start = 1'b1; op = 4'd6; a = 8'hFF; b = 8'h05;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, result, zero, carry, negative, overflow, illegal} !== 15'd0) begin
            errors++;
            $display("FAIL midshift reset: got %h, want 0",
                     {busy, done, result, zero, carry, negative, overflow, illegal});
        end
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL discarded op: dones=%0d busy=%b, want 0/0", dones, busy);
        end
        run_op("add_after_rst", 4'd0, 8'h02, 8'h03, 8'h05, 5'b00000, 1);
    endtask

    task automatic test_random;
        logic [3:0] o;
        logic [7:0] x, y, er;
        logic [4:0] ef;
        int lat;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            if (i % 2 == 0) o = 4'($urandom_range(0, 8));
            x = 8'($urandom);
            y = 8'($urandom);
            model(o, x, y, er, ef, lat);
            run_op($sformatf("rand%0d_op%0d", i, o), o, x, y, er, ef, lat);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_add;
        test_back_to_back;
        test_sra_ignore;
        test_sll;
        test_passb_illegal;
        test_reset_midshift;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
